mq_sfifo: RTL and testbench

- Multi-channel synchronous FIFO; next generation of the single-queue sfifo.
- NUM_CH independent queues share one 1R1W RAM, statically partitioned. The RAM address is {channel, pointer}.
- One channel-addressed write and one channel-addressed read per cycle.
- Per-channel level and status flags, per-channel synchronous flush, and overflow/underflow error pulses.
- Sits between RDMA TX schedulers and per-QP/per-tenant datapaths, where queues must be isolated.

---
 rtl/mq_sfifo_if.sv | 34 +++
 rtl/mq_sfifo.sv | 123 ++++++++++++
 tb/tb_mq_sfifo.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mq_sfifo_if.sv
// Bundle of the mq_sfifo write/read/flush/status signals between a client and the FIFO.
interface mq_sfifo_if #(
   parameter int WIDTH_DATA = 32,
   parameter int WIDTH_ADDR = 6,
   parameter int NUM_CH     = 4,
   parameter int WIDTH_CH   = 2
);
   logic                             wen;
   logic [WIDTH_CH-1:0]              wch;
   logic [WIDTH_DATA-1:0]            wdata;
   logic                             ren;
   logic [WIDTH_CH-1:0]              rch;
   logic [WIDTH_DATA-1:0]            rdata;
   logic                             rvalid;
   logic [WIDTH_CH-1:0]              rch_o;
   logic [NUM_CH-1:0]                flush;
   logic [NUM_CH-1:0]                full;
   logic [NUM_CH-1:0]                alfull;
   logic [NUM_CH-1:0]                empty;
   logic [NUM_CH-1:0]                alempty;
   logic [NUM_CH*(WIDTH_ADDR+1)-1:0] deep;
   logic [NUM_CH-1:0]                ovf_err;
   logic [NUM_CH-1:0]                udf_err;

   modport master (
      output wen, wch, wdata, ren, rch, flush,
      input  rdata, rvalid, rch_o, full, alfull, empty, alempty, deep, ovf_err, udf_err
   );

   modport slave (
      input  wen, wch, wdata, ren, rch, flush,
      output rdata, rvalid, rch_o, full, alfull, empty, alempty, deep, ovf_err, udf_err
   );
endinterface

// File: rtl/mq_sfifo.sv
// Multi-channel synchronous FIFO: NUM_CH isolated queues statically partitioned in one
// 1R1W RAM addressed as {channel, pointer}, with per-channel flags, flush and error pulses.
module mq_sfifo #(
   parameter int WIDTH_DATA    = 32,
   parameter int WIDTH_ADDR    = 6,
   parameter int NUM_CH        = 4,
   parameter int WIDTH_CH      = 2,
   parameter int WATERAGE_UP   = 1,
   parameter int WATERAGE_DOWN = 1
) (
   input logic       sys_clk,
   input logic       sys_rst,
   mq_sfifo_if.slave bus
);
   localparam int A     = WIDTH_ADDR;
   localparam int DEPTH = 1 << WIDTH_ADDR;

   localparam logic [A:0] LVL_FULL = (A+1)'(DEPTH);
   localparam logic [A:0] LVL_AF   = (A+1)'(DEPTH - WATERAGE_UP);
   localparam logic [A:0] LVL_AE   = (A+1)'(WATERAGE_DOWN);

   logic [A-1:0]          wptr [NUM_CH];
   logic [A-1:0]          rptr [NUM_CH];
   logic [A:0]            cnt  [NUM_CH];
   logic [WIDTH_DATA-1:0] mem  [NUM_CH*DEPTH];

   logic [NUM_CH-1:0]     full_v, empty_v;
   logic [NUM_CH-1:0]     w_sel, r_sel, ovf_nxt, udf_nxt;
   logic                  wch_ok, rch_ok, w_acc, r_acc;
   logic [WIDTH_CH+A-1:0] waddr, raddr;

   // Status flags and occupancy straight from the registered counts.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_flags
      assign full_v[c]      = (cnt[c] == LVL_FULL);
      assign empty_v[c]     = (cnt[c] == '0);
      assign bus.alfull[c]  = (cnt[c] >= LVL_AF);
      assign bus.alempty[c] = (cnt[c] <= LVL_AE);
      assign bus.deep[c*(A+1) +: A+1] = cnt[c];
   end

   assign bus.full  = full_v;
   assign bus.empty = empty_v;

   // Out-of-range channel codes (non-power-of-2 NUM_CH) are silently ignored.
   assign wch_ok = (32'(bus.wch) < NUM_CH);
   assign rch_ok = (32'(bus.rch) < NUM_CH);
   assign w_acc  = bus.wen && wch_ok && !full_v[bus.wch]  && !bus.flush[bus.wch];
   assign r_acc  = bus.ren && rch_ok && !empty_v[bus.rch] && !bus.flush[bus.rch];
   assign waddr  = {bus.wch, wptr[bus.wch]};
   assign raddr  = {bus.rch, rptr[bus.rch]};

   // Decode accepted operations and rejected-op errors onto per-channel strobes.
   always_comb begin
      w_sel   = '0;
      r_sel   = '0;
      ovf_nxt = '0;
      udf_nxt = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_sel[c]   = w_acc && (bus.wch == WIDTH_CH'(c));
         r_sel[c]   = r_acc && (bus.rch == WIDTH_CH'(c));
         ovf_nxt[c] = bus.wen && (bus.wch == WIDTH_CH'(c)) && full_v[c]  && !bus.flush[c];
         udf_nxt[c] = bus.ren && (bus.rch == WIDTH_CH'(c)) && empty_v[c] && !bus.flush[c];
      end
   end

   // Per-channel pointers and occupancy; flush wins over any same-cycle traffic.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wptr[c] <= '0;
            rptr[c] <= '0;
            cnt[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (bus.flush[c]) begin
               wptr[c] <= '0;
               rptr[c] <= '0;
               cnt[c]  <= '0;
            end else begin
               if (w_sel[c]) wptr[c] <= wptr[c] + 1'b1;
               if (r_sel[c]) rptr[c] <= rptr[c] + 1'b1;
               case ({w_sel[c], r_sel[c]})
                  2'b10:   cnt[c] <= cnt[c] + 1'b1;
                  2'b01:   cnt[c] <= cnt[c] - 1'b1;
                  default: cnt[c] <= cnt[c];
               endcase
            end
         end
      end
   end

   // Shared storage write port; contents are intentionally left unreset.
   always_ff @(posedge sys_clk) begin
      if (w_acc) mem[waddr] <= bus.wdata;
   end

   // Registered read port: old data on same-address collisions, rdata/rch_o hold when idle.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         bus.rvalid <= 1'b0;
         bus.rdata  <= '0;
         bus.rch_o  <= '0;
      end else begin
         bus.rvalid <= r_acc;
         if (r_acc) begin
            bus.rdata <= mem[raddr];
            bus.rch_o <= bus.rch;
         end
      end
   end

   // One-cycle error pulses for rejected writes to full / reads from empty channels.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         bus.ovf_err <= '0;
         bus.udf_err <= '0;
      end else begin
         bus.ovf_err <= ovf_nxt;
         bus.udf_err <= udf_nxt;
      end
   end
endmodule

// File: tb/tb_mq_sfifo.sv
// Self-checking bench for mq_sfifo against a per-channel queue model.
module tb_mq_sfifo;
   localparam int WD = 32, WA = 6, NC = 4, WC = 2, DEPTH = 64;
   localparam int DW = NC*(WA+1);

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;

   mq_sfifo_if #(.WIDTH_DATA(WD), .WIDTH_ADDR(WA), .NUM_CH(NC), .WIDTH_CH(WC)) bus ();

   mq_sfifo #(.WIDTH_DATA(WD), .WIDTH_ADDR(WA), .NUM_CH(NC), .WIDTH_CH(WC),
              .WATERAGE_UP(1), .WATERAGE_DOWN(1)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   typedef logic [WD-1:0] word_q_t [$];
   word_q_t mq [NC];

   logic          exp_rvalid = 1'b0;
   logic [WD-1:0] exp_rdata  = '0;
   logic [WC-1:0] exp_rch    = '0;
   logic [NC-1:0] exp_ovf    = '0;
   logic [NC-1:0] exp_udf    = '0;
   int n_checks = 0;
   int n_errs   = 0;

   function automatic logic [DW-1:0] m_deep();
      logic [DW-1:0] v = '0;
      for (int c = 0; c < NC; c++) v[c*(WA+1) +: WA+1] = (WA+1)'(mq[c].size());
      return v;
   endfunction

   function automatic logic [NC-1:0] m_empty();
      logic [NC-1:0] v = '0;
      for (int c = 0; c < NC; c++) v[c] = (mq[c].size() == 0);
      return v;
   endfunction

   function automatic logic [NC-1:0] m_full();
      logic [NC-1:0] v = '0;
      for (int c = 0; c < NC; c++) v[c] = (mq[c].size() == DEPTH);
      return v;
   endfunction

   function automatic logic [NC-1:0] m_alfull();
      logic [NC-1:0] v = '0;
      for (int c = 0; c < NC; c++) v[c] = (mq[c].size() >= DEPTH - 1);
      return v;
   endfunction

   function automatic logic [NC-1:0] m_alempty();
      logic [NC-1:0] v = '0;
      for (int c = 0; c < NC; c++) v[c] = (mq[c].size() <= 1);
      return v;
   endfunction

   function automatic int deep_of(input int c);
      logic [DW-1:0] d;
      d = bus.deep;
      return int'(d[c*(WA+1) +: WA+1]);
   endfunction

   // One clock of stimulus; called at a negedge, returns at the next negedge with model updated.
   task automatic drive(input logic w, input int wc, input logic [WD-1:0] wd,
                        input logic r, input int rc, input logic [NC-1:0] fl);
      int   wsz, rsz;
      logic wa, ra;
      bus.wen = w; bus.wch = WC'(wc); bus.wdata = wd;
      bus.ren = r; bus.rch = WC'(rc); bus.flush = fl;
      wsz = mq[wc].size();
      rsz = mq[rc].size();
      wa  = w && !fl[wc] && (wsz < DEPTH);
      ra  = r && !fl[rc] && (rsz > 0);
      exp_ovf = '0;
      exp_udf = '0;
      if (w && !fl[wc] && wsz == DEPTH) exp_ovf[wc] = 1'b1;
      if (r && !fl[rc] && rsz == 0)     exp_udf[rc] = 1'b1;
      @(posedge sys_clk);
      exp_rvalid = ra;
      if (ra) begin
         exp_rdata = mq[rc].pop_front();
         exp_rch   = WC'(rc);
      end
      if (wa) mq[wc].push_back(wd);
      for (int c = 0; c < NC; c++) if (fl[c]) mq[c].delete();
      @(negedge sys_clk);
      bus.wen = 1'b0; bus.ren = 1'b0; bus.flush = '0;
   endtask

   task automatic test_reset();
      n_checks++; if (bus.empty !== 4'hF) begin n_errs++; $display("FAIL reset_empty: got %h expected f", bus.empty); end
      n_checks++; if (bus.alempty !== 4'hF) begin n_errs++; $display("FAIL reset_alempty: got %h expected f", bus.alempty); end
      n_checks++; if (bus.full !== 4'h0 || bus.alfull !== 4'h0) begin n_errs++; $display("FAIL reset_full: got %h/%h expected 0/0", bus.full, bus.alfull); end
      n_checks++; if (bus.deep !== '0) begin n_errs++; $display("FAIL reset_deep: got %h expected 0", bus.deep); end
      n_checks++; if (bus.rvalid !== 1'b0 || bus.rdata !== '0 || bus.rch_o !== '0) begin n_errs++; $display("FAIL reset_read: got %b/%h/%h expected 0/0/0", bus.rvalid, bus.rdata, bus.rch_o); end
      n_checks++; if (bus.ovf_err !== '0 || bus.udf_err !== '0) begin n_errs++; $display("FAIL reset_err: got %h/%h expected 0/0", bus.ovf_err, bus.udf_err); end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 4; i++) drive(1'b1, 2, 32'hA0 + i, 1'b0, 0, '0);
      n_checks++; if (deep_of(2) !== 4) begin n_errs++; $display("FAIL basic_deep: got %0d expected 4", deep_of(2)); end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 0, '0, 1'b1, 2, '0);
         n_checks++;
         if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hA0 + i || bus.rch_o !== 2'd2) begin
            n_errs++; $display("FAIL basic_read%0d: got %b/%h/%h expected 1/%h/2", i, bus.rvalid, bus.rdata, bus.rch_o, 32'hA0 + i);
         end
      end
      n_checks++; if (bus.empty[2] !== 1'b1) begin n_errs++; $display("FAIL basic_empty: got %b expected 1", bus.empty[2]); end
      drive(1'b0, 0, '0, 1'b0, 0, '0);
      n_checks++; if (bus.rvalid !== 1'b0 || bus.rdata !== 32'hA3) begin n_errs++; $display("FAIL basic_hold: got %b/%h expected 0/a3", bus.rvalid, bus.rdata); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1, $urandom, 1'b0, 0, '0);
         drive(1'b0, 0, '0, 1'b1, 1, '0);
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 1, $urandom, 1'b0, 0, '0);
         n_checks++;
         if (bus.alfull[1] !== (i + 1 >= 63) || bus.full[1] !== (i + 1 == 64)) begin
            n_errs++; $display("FAIL fill_flags@%0d: got af=%b f=%b expected af=%b f=%b", i + 1, bus.alfull[1], bus.full[1], (i + 1 >= 63), (i + 1 == 64));
         end
      end
      drive(1'b1, 1, 32'hDEAD_BEEF, 1'b0, 0, '0);
      n_checks++; if (bus.ovf_err !== 4'b0010 || deep_of(1) !== 64) begin n_errs++; $display("FAIL fill_ovf: got ovf=%h deep=%0d expected 2/64", bus.ovf_err, deep_of(1)); end
      drive(1'b0, 0, '0, 1'b0, 0, '0);
      n_checks++; if (bus.ovf_err !== 4'b0000) begin n_errs++; $display("FAIL fill_ovf_pulse: got %h expected 0", bus.ovf_err); end
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 0, '0, 1'b1, 1, '0);
         n_checks++;
         if (bus.rvalid !== 1'b1 || bus.rdata !== exp_rdata) begin
            n_errs++; $display("FAIL fill_read%0d: got %b/%h expected 1/%h", i, bus.rvalid, bus.rdata, exp_rdata);
         end
      end
      n_checks++; if (bus.empty[1] !== 1'b1) begin n_errs++; $display("FAIL fill_empty: got %b expected 1", bus.empty[1]); end
   endtask

   task automatic test_simul();
      logic [WD-1:0] d;
      for (int i = 0; i < 3; i++) drive(1'b1, 0, $urandom, 1'b0, 0, '0);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 0, $urandom, 1'b1, 0, '0);
         n_checks++;
         if (deep_of(0) !== 3 || bus.rvalid !== 1'b1 || bus.rdata !== exp_rdata) begin
            n_errs++; $display("FAIL simul_ch0_%0d: got deep=%0d %b/%h expected 3 1/%h", i, deep_of(0), bus.rvalid, bus.rdata, exp_rdata);
         end
      end
      d = $urandom;
      drive(1'b1, 3, d, 1'b1, 3, '0);
      n_checks++;
      if (bus.udf_err !== 4'b1000 || deep_of(3) !== 1 || bus.rvalid !== 1'b0) begin
         n_errs++; $display("FAIL simul_empty_ch3: got udf=%h deep=%0d rv=%b expected 8/1/0", bus.udf_err, deep_of(3), bus.rvalid);
      end
      drive(1'b0, 0, '0, 1'b1, 3, '0);
      n_checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== d || bus.udf_err !== '0) begin n_errs++; $display("FAIL simul_ch3_read: got %b/%h/%h expected 1/%h/0", bus.rvalid, bus.rdata, bus.udf_err, d); end
   endtask

   task automatic test_interleave();
      for (int i = 0; i < 8; i++) drive(1'b1, 1, $urandom, 1'b0, 0, '0);
      for (int i = 0; i < 24; i++) begin
         drive(1'b1, (i % 2) ? 3 : 0, $urandom, (mq[1].size() > 0), 1, '0);
         n_checks++;
         if (bus.deep !== m_deep() || bus.rvalid !== exp_rvalid || (exp_rvalid && (bus.rdata !== exp_rdata || bus.rch_o !== 2'd1))) begin
            n_errs++; $display("FAIL interleave%0d: got deep=%h %b/%h/%h expected deep=%h %b/%h/1", i, bus.deep, bus.rvalid, bus.rdata, bus.rch_o, m_deep(), exp_rvalid, exp_rdata);
         end
      end
      while (mq[3].size() > 0) begin
         drive(1'b0, 0, '0, 1'b1, 3, '0);
         n_checks++;
         if (bus.rvalid !== 1'b1 || bus.rdata !== exp_rdata || bus.rch_o !== 2'd3) begin
            n_errs++; $display("FAIL interleave_ch3: got %b/%h/%h expected 1/%h/3", bus.rvalid, bus.rdata, bus.rch_o, exp_rdata);
         end
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) drive(1'b1, 2, $urandom, 1'b0, 0, '0);
      drive(1'b0, 0, '0, 1'b1, 2, '0);
      n_checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== exp_rdata) begin n_errs++; $display("FAIL flush_preread: got %b/%h expected 1/%h", bus.rvalid, bus.rdata, exp_rdata); end
      drive(1'b1, 2, $urandom, 1'b1, 2, 4'b0100);
      n_checks++;
      if (deep_of(2) !== 0 || bus.ovf_err !== '0 || bus.udf_err !== '0 || bus.rvalid !== 1'b0) begin
         n_errs++; $display("FAIL flush_ch2: got deep=%0d ovf=%h udf=%h rv=%b expected 0/0/0/0", deep_of(2), bus.ovf_err, bus.udf_err, bus.rvalid);
      end
      n_checks++; if (bus.deep !== m_deep()) begin n_errs++; $display("FAIL flush_others: got %h expected %h", bus.deep, m_deep()); end
      while (mq[0].size() > 0) begin
         drive(1'b0, 0, '0, 1'b1, 0, '0);
         n_checks++;
         if (bus.rvalid !== 1'b1 || bus.rdata !== exp_rdata) begin
            n_errs++; $display("FAIL flush_ch0_data: got %b/%h expected 1/%h", bus.rvalid, bus.rdata, exp_rdata);
         end
      end
   endtask

   task automatic test_random();
      logic [NC-1:0] fl;
      for (int i = 0; i < 600; i++) begin
         fl = '0;
         for (int c = 0; c < NC; c++) if ($urandom_range(0, 39) == 0) fl[c] = 1'b1;
         drive($urandom_range(0, 2) != 0, $urandom_range(0, NC-1), $urandom,
               $urandom_range(0, 2) == 0, $urandom_range(0, NC-1), fl);
         n_checks++;
         if (bus.rvalid !== exp_rvalid || bus.rdata !== exp_rdata || (exp_rvalid && bus.rch_o !== exp_rch)) begin
            n_errs++; $display("FAIL rand_read%0d: got %b/%h/%h expected %b/%h/%h", i, bus.rvalid, bus.rdata, bus.rch_o, exp_rvalid, exp_rdata, exp_rch);
         end
         n_checks++;
         if (bus.deep !== m_deep() || bus.empty !== m_empty() || bus.full !== m_full() ||
             bus.alfull !== m_alfull() || bus.alempty !== m_alempty()) begin
            n_errs++; $display("FAIL rand_state%0d: got deep=%h e=%h f=%h af=%h ae=%h expected deep=%h e=%h f=%h af=%h ae=%h", i,
                               bus.deep, bus.empty, bus.full, bus.alfull, bus.alempty, m_deep(), m_empty(), m_full(), m_alfull(), m_alempty());
         end
         n_checks++;
         if (bus.ovf_err !== exp_ovf || bus.udf_err !== exp_udf) begin
            n_errs++; $display("FAIL rand_err%0d: got ovf=%h udf=%h expected ovf=%h udf=%h", i, bus.ovf_err, bus.udf_err, exp_ovf, exp_udf);
         end
      end
   endtask

   task automatic test_async_reset();
      drive(1'b0, 0, '0, 1'b0, 0, 4'hF);
      for (int i = 0; i < 3; i++) drive(1'b1, 0, $urandom, 1'b0, 0, '0);
      drive(1'b1, 1, $urandom, 1'b0, 0, '0);
      bus.ren = 1'b1; bus.rch = 2'd0;
      @(posedge sys_clk);
      #2;
      n_checks++; if (bus.rvalid !== 1'b1) begin n_errs++; $display("FAIL arst_pre: got rvalid=%b expected 1", bus.rvalid); end
      sys_rst = 1'b1;
      #1;
      n_checks++; if (bus.rvalid !== 1'b0) begin n_errs++; $display("FAIL arst_rvalid: got %b expected 0", bus.rvalid); end
      n_checks++; if (bus.empty !== 4'hF || bus.deep !== '0) begin n_errs++; $display("FAIL arst_state: got e=%h deep=%h expected f/0", bus.empty, bus.deep); end
      for (int c = 0; c < NC; c++) mq[c].delete();
      exp_rdata = '0; exp_rch = '0; exp_rvalid = 1'b0;
      bus.ren = 1'b0;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      drive(1'b0, 0, '0, 1'b1, 0, '0);
      n_checks++; if (bus.udf_err !== 4'b0001 || bus.rvalid !== 1'b0) begin n_errs++; $display("FAIL arst_after: got udf=%h rv=%b expected 1/0", bus.udf_err, bus.rvalid); end
   endtask

   initial begin
      bus.wen = 1'b0; bus.wch = '0; bus.wdata = '0;
      bus.ren = 1'b0; bus.rch = '0; bus.flush = '0;
      sys_rst = 1'b1;
      repeat (2) @(negedge sys_clk);
      test_reset();
      sys_rst = 1'b0;
      @(negedge sys_clk);
      test_reset();
      test_basic();
      test_fill();
      test_simul();
      test_interleave();
      test_flush();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule
